column_pair_packer: RTL



---
 rtl/column_pair_packer_pkg.sv | 20 ++
 rtl/column_pair_packer_bram.sv | 35 +++
 rtl/column_pair_packer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/column_pair_packer_pkg.sv
// rtl/column_pair_packer_pkg.sv - shared types for the row-to-column pairing stage
// Purpose: row FSM state encoding and the {odd, even} pair type shared with
//          the column lifting unit.
// Ports:   none (package).
package column_pair_packer_pkg;

  localparam int unsigned PairDataWidth = 16;

  typedef enum logic {
    EVEN_ROW = 1'b0,
    ODD_ROW  = 1'b1
  } row_state_e;

  // Lifting-unit port convention: odd-row sample in the upper half.
  typedef struct packed {
    logic [PairDataWidth-1:0] odd;
    logic [PairDataWidth-1:0] even;
  } pair_t;

endpackage

// File: rtl/column_pair_packer_bram.sv
// rtl/column_pair_packer_bram.sv - dual-port line buffer, port A write, port B read
// Purpose: simple dual-port RAM with a registered read port.
// Ports:   clk_i; a_we_i/a_addr_i/a_data_i write port;
//          b_addr_i read address, b_data_o read data one cycle later.
module column_pair_packer_bram #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned AddrWidth = 9
) (
  input  logic                 clk_i,
  input  logic                 a_we_i,
  input  logic [AddrWidth-1:0] a_addr_i,
  input  logic [DataWidth-1:0] a_data_i,
  input  logic [AddrWidth-1:0] b_addr_i,
  output logic [DataWidth-1:0] b_data_o
);

  logic [DataWidth-1:0] mem_q [2**AddrWidth];
  logic [DataWidth-1:0] b_data_q;

  // Write-first on a same-address collision: a one-sample even row is
  // written and read back at address 0 in the same cycle.
  always_ff @(posedge clk_i) begin
    if (a_we_i) begin
      mem_q[a_addr_i] <= a_data_i;
    end
    if (a_we_i && (a_addr_i == b_addr_i)) begin
      b_data_q <= a_data_i;
    end else begin
      b_data_q <= mem_q[b_addr_i];
    end
  end

  assign b_data_o = b_data_q;

endmodule

// File: rtl/column_pair_packer.sv
// rtl/column_pair_packer.sv - pairs each even row with the following odd row per column
// Purpose: buffers even rows, emits {odd, even} pairs during odd rows, regenerates
//          sof/eol markers and flags frame-shape errors.
// Ports:   clk_i, rst_i (async active-high);
//          s_valid_i/s_ready_o/s_sof_i/s_eol_i/s_data_i raster sample input;
//          m_valid_o/m_ready_i/m_sof_o/m_eol_o/m_data_o pair output;
//          err_o sticky error, cleared by an accepted s_sof_i.
module column_pair_packer
  import column_pair_packer_pkg::*;
#(
  parameter int unsigned DataWidth       = 16,
  parameter int unsigned MaximumSideSize = 512
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   s_ready_o,
  input  logic                   s_valid_i,
  input  logic                   s_sof_i,
  input  logic                   s_eol_i,
  input  logic [DataWidth-1:0]   s_data_i,
  input  logic                   m_ready_i,
  output logic                   m_valid_o,
  output logic                   m_sof_o,
  output logic                   m_eol_o,
  output logic [2*DataWidth-1:0] m_data_o,
  output logic                   err_o
);

  localparam int unsigned AddrWidth = $clog2(MaximumSideSize);
  localparam logic [AddrWidth-1:0] ColMax = AddrWidth'(MaximumSideSize - 1);

  row_state_e             state_q, state_d;
  logic [AddrWidth-1:0]   col_q, col_d, col_inc;
  logic [AddrWidth-1:0]   even_last_q, even_last_d;
  logic                   sof_pending_q, sof_pending_d;
  logic                   err_q, err_d;
  logic                   m_valid_q, m_valid_d;
  logic                   m_sof_q, m_sof_d;
  logic                   m_eol_q, m_eol_d;
  logic [2*DataWidth-1:0] m_data_q, m_data_d;

  logic                   accept;
  logic                   buf_we;
  logic [AddrWidth-1:0]   buf_waddr;
  logic [DataWidth-1:0]   buf_rdata;

  // Even rows never stall on a pending pair; odd rows stall only when the
  // output register is full and not draining.
  assign s_ready_o = ~rst_i & ((state_q == EVEN_ROW) | ~m_valid_q | m_ready_i);
  assign accept    = s_valid_i & s_ready_o;

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    even_last_d   = even_last_q;
    sof_pending_d = sof_pending_q;
    err_d         = err_q;
    m_valid_d     = m_valid_q & ~m_ready_i;
    m_sof_d       = m_sof_q;
    m_eol_d       = m_eol_q;
    m_data_d      = m_data_q;
    buf_we        = 1'b0;
    buf_waddr     = col_q;
    col_inc       = (col_q == ColMax) ? '0 : col_q + AddrWidth'(1);

    if (accept) begin
      if (s_sof_i) begin
        // Frame start always restarts at column 0 of an even row; a
        // half-finished pair-line is dropped and reported.
        buf_we        = 1'b1;
        buf_waddr     = '0;
        sof_pending_d = 1'b1;
        err_d         = (state_q == ODD_ROW) && (col_q != '0);
        if (s_eol_i) begin
          state_d     = ODD_ROW;
          col_d       = '0;
          even_last_d = '0;
        end else begin
          state_d = EVEN_ROW;
          col_d   = AddrWidth'(1);
        end
      end else if (state_q == EVEN_ROW) begin
        buf_we = 1'b1;
        if (s_eol_i) begin
          state_d     = ODD_ROW;
          col_d       = '0;
          even_last_d = col_q;
        end else begin
          col_d = col_inc;
          if (col_q == ColMax) err_d = 1'b1;
        end
      end else begin
        m_valid_d     = 1'b1;
        m_data_d      = {s_data_i, buf_rdata};
        m_sof_d       = sof_pending_q;
        m_eol_d       = s_eol_i;
        sof_pending_d = 1'b0;
        if (col_q > even_last_q) err_d = 1'b1;
        if (s_eol_i) begin
          state_d = EVEN_ROW;
          col_d   = '0;
          if (col_q != even_last_q) err_d = 1'b1;
        end else begin
          col_d = col_inc;
          if (col_q == ColMax) err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= EVEN_ROW;
      col_q         <= '0;
      even_last_q   <= '0;
      sof_pending_q <= 1'b0;
      err_q         <= 1'b0;
      m_valid_q     <= 1'b0;
      m_sof_q       <= 1'b0;
      m_eol_q       <= 1'b0;
      m_data_q      <= '0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      even_last_q   <= even_last_d;
      sof_pending_q <= sof_pending_d;
      err_q         <= err_d;
      m_valid_q     <= m_valid_d;
      m_sof_q       <= m_sof_d;
      m_eol_q       <= m_eol_d;
      m_data_q      <= m_data_d;
    end
  end

  // Reading the next column address prefetches buffer[col] for the cycle
  // each odd sample arrives, so odd rows run without bubbles.
  column_pair_packer_bram #(
    .DataWidth(DataWidth),
    .AddrWidth(AddrWidth)
  ) u_line_buf (
    .clk_i   (clk_i),
    .a_we_i  (buf_we),
    .a_addr_i(buf_waddr),
    .a_data_i(s_data_i),
    .b_addr_i(col_d),
    .b_data_o(buf_rdata)
  );

  assign m_valid_o = m_valid_q;
  assign m_sof_o   = m_sof_q;
  assign m_eol_o   = m_eol_q;
  assign m_data_o  = m_data_q;
  assign err_o     = err_q;

endmodule
